// File: rtl/coreresetp_pcie_hotreset_mc_pkg.sv
// Shared types and constants for the multi-channel PCIe HotReset workaround.
// Optional HOTRESET_DETECT timeout is enabled by CORERESETP_HOTRESET_TIMEOUT_EN.
package coreresetp_hotreset_pkg;

  localparam int LTSSM_W = 5;
  localparam int CNT_W   = 8;
  localparam int TMO_W   = 16;

  localparam logic [LTSSM_W-1:0] LTSSM_HOT_RESET    = 5'b10100;
  localparam logic [LTSSM_W-1:0] LTSSM_DISABLED     = 5'b10000;
  localparam logic [LTSSM_W-1:0] LTSSM_DETECT_QUIET = 5'b00000;

  // Bit positions inside the per-channel level/entry flag vectors
  localparam int LVL_HR  = 0;
  localparam int LVL_DIS = 1;
  localparam int LVL_DQ  = 2;

  typedef enum logic [1:0] {
    IDLE            = 2'b00,
    HOTRESET_DETECT = 2'b01,
    DETECT_QUIET    = 2'b10,
    RESET_ASSERT    = 2'b11
  } state_t;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/coreresetp_pcie_hotreset_mc_if.sv
// Per-channel APB snoop bundle (select, write, read data) for the HotReset block.
interface coreresetp_pcie_hotreset_mc_if #(
  parameter int NUM_SDIF = 1
);
  logic [NUM_SDIF-1:0]    psel;
  logic [NUM_SDIF-1:0]    pwrite;
  logic [32*NUM_SDIF-1:0] prdata;

  modport master (output psel, output pwrite, output prdata);
  modport slave  (input  psel, input  pwrite, input  prdata);
endinterface

// File: rtl/coreresetp_pcie_hotreset_mc_chan.sv
// One SDIF channel: LTSSM snoop pipeline, HotReset FSM, counters, reset synchroniser.
// CORERESETP_HOTRESET_TIMEOUT_EN adds the HOTRESET_DETECT dwell timeout.
module coreresetp_hotreset_chan
  import coreresetp_hotreset_pkg::*;
#(
  parameter int LTSSM_LSB      = 26,
  parameter int HOLD_CYCLES    = 100,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic             CLK_BASE,
  input  logic             sdif_core_reset_n_0,
  input  logic             psel,
  input  logic             pwrite,
  input  logic [31:0]      prdata,
  output logic             sdif_core_reset_n,
  output logic             hot_reset_active,
  output logic [CNT_W-1:0] hot_reset_count,
  output logic             timeout_p
);

  localparam int                HOLD_W    = $clog2(HOLD_CYCLES);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);

  logic [LTSSM_W-1:0] ltssm_q1_reg, ltssm_q2_reg;
  logic               psel_q1_reg, psel_q2_reg;
  logic               pwrite_q1_reg, pwrite_q2_reg;
  logic               no_apb_read;
  logic [2:0]         lvl_next, lvl_reg, lvl_q_reg, entry_reg;

  state_t             state_reg, state_next;
  logic               hot_reset_n_reg, hot_reset_n_next;
  logic [HOLD_W-1:0]  hold_cnt_reg, hold_cnt_next;
  logic [CNT_W-1:0]   count_reg, count_next;
  logic               active_reg;

  logic               core_areset_n;
  logic [1:0]         rst_sync_reg;

  // Only the LTSSM field is meaningful; the rest of the word is ignored
  logic unused_prdata;
  assign unused_prdata = ^prdata;

`ifdef CORERESETP_HOTRESET_TIMEOUT_EN
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);
  logic [TMO_W-1:0] tmo_cnt_reg, tmo_cnt_next;
  logic             timeout_p_reg, timeout_p_next;
`else
  localparam int unused_timeout_cycles = TIMEOUT_CYCLES;
`endif

  // Level flags are meaningless while an APB read owns PRDATA
  assign no_apb_read = !psel_q2_reg | pwrite_q2_reg;
  always_comb begin
    lvl_next = 3'b000;
    if (no_apb_read) begin
      lvl_next[LVL_HR]  = (ltssm_q2_reg == LTSSM_HOT_RESET);
      lvl_next[LVL_DIS] = (ltssm_q2_reg == LTSSM_DISABLED);
      lvl_next[LVL_DQ]  = (ltssm_q2_reg == LTSSM_DETECT_QUIET);
    end
  end

  always_ff @(posedge CLK_BASE or negedge sdif_core_reset_n_0) begin
    if (!sdif_core_reset_n_0) begin
      ltssm_q1_reg  <= '0;
      ltssm_q2_reg  <= '0;
      psel_q1_reg   <= 1'b0;
      psel_q2_reg   <= 1'b0;
      pwrite_q1_reg <= 1'b0;
      pwrite_q2_reg <= 1'b0;
      lvl_reg       <= '0;
      lvl_q_reg     <= '0;
      entry_reg     <= '0;
    end else begin
      ltssm_q1_reg  <= prdata[LTSSM_LSB +: LTSSM_W];
      ltssm_q2_reg  <= ltssm_q1_reg;
      psel_q1_reg   <= psel;
      psel_q2_reg   <= psel_q1_reg;
      pwrite_q1_reg <= pwrite;
      pwrite_q2_reg <= pwrite_q1_reg;
      lvl_reg       <= lvl_next;
      lvl_q_reg     <= lvl_reg;
      entry_reg     <= lvl_reg & ~lvl_q_reg;
    end
  end

  always_comb begin
    state_next       = state_reg;
    hot_reset_n_next = hot_reset_n_reg;
    hold_cnt_next    = hold_cnt_reg;
    count_next       = count_reg;
`ifdef CORERESETP_HOTRESET_TIMEOUT_EN
    tmo_cnt_next     = tmo_cnt_reg;
    timeout_p_next   = 1'b0;
`endif
    case (state_reg)
      IDLE: begin
        if (entry_reg[LVL_HR] || entry_reg[LVL_DIS]) begin
          state_next = HOTRESET_DETECT;
`ifdef CORERESETP_HOTRESET_TIMEOUT_EN
          tmo_cnt_next = '0;
`endif
        end
      end
      HOTRESET_DETECT: begin
        // Detect.Quiet entry takes priority over a coincident timeout
        if (entry_reg[LVL_DQ]) begin
          state_next       = DETECT_QUIET;
          hot_reset_n_next = 1'b0;
        end
`ifdef CORERESETP_HOTRESET_TIMEOUT_EN
        else if (tmo_cnt_reg == TMO_LAST) begin
          state_next     = IDLE;
          timeout_p_next = 1'b1;
        end else begin
          tmo_cnt_next = tmo_cnt_reg + 1'b1;
        end
`endif
      end
      DETECT_QUIET: begin
        hold_cnt_next = '0;
        state_next    = RESET_ASSERT;
      end
      RESET_ASSERT: begin
        if (hold_cnt_reg == HOLD_LAST) begin
          state_next       = IDLE;
          hot_reset_n_next = 1'b1;
          count_next       = sat_inc(count_reg);
        end else begin
          hold_cnt_next = hold_cnt_reg + 1'b1;
        end
      end
      default: begin
        state_next       = IDLE;
        hot_reset_n_next = 1'b1;
      end
    endcase
  end

  always_ff @(posedge CLK_BASE or negedge sdif_core_reset_n_0) begin
    if (!sdif_core_reset_n_0) begin
      state_reg       <= IDLE;
      hot_reset_n_reg <= 1'b1;
      hold_cnt_reg    <= '0;
      count_reg       <= '0;
      active_reg      <= 1'b0;
`ifdef CORERESETP_HOTRESET_TIMEOUT_EN
      tmo_cnt_reg     <= '0;
      timeout_p_reg   <= 1'b0;
`endif
    end else begin
      state_reg       <= state_next;
      hot_reset_n_reg <= hot_reset_n_next;
      hold_cnt_reg    <= hold_cnt_next;
      count_reg       <= count_next;
      active_reg      <= (state_next == DETECT_QUIET) || (state_next == RESET_ASSERT);
`ifdef CORERESETP_HOTRESET_TIMEOUT_EN
      tmo_cnt_reg     <= tmo_cnt_next;
      timeout_p_reg   <= timeout_p_next;
`endif
    end
  end

  // Assert immediately from either source, release synchronously after two flops
  assign core_areset_n = hot_reset_n_reg & sdif_core_reset_n_0;
  always_ff @(posedge CLK_BASE or negedge core_areset_n) begin
    if (!core_areset_n) begin
      rst_sync_reg <= 2'b00;
    end else begin
      rst_sync_reg <= {rst_sync_reg[0], 1'b1};
    end
  end

  assign sdif_core_reset_n = rst_sync_reg[1];
  assign hot_reset_active  = active_reg;
  assign hot_reset_count   = count_reg;
`ifdef CORERESETP_HOTRESET_TIMEOUT_EN
  assign timeout_p = timeout_p_reg;
`else
  assign timeout_p = 1'b0;
`endif

endmodule

// File: rtl/coreresetp_pcie_hotreset_mc.sv
// Multi-channel PCIe HotReset workaround top: one independent channel per SDIF.
// CORERESETP_HOTRESET_TIMEOUT_EN enables the per-channel HOTRESET_DETECT timeout.
module coreresetp_pcie_hotreset_mc
  import coreresetp_hotreset_pkg::*;
#(
  parameter int NUM_SDIF       = 1,
  parameter int LTSSM_LSB      = 26,
  parameter int HOLD_CYCLES    = 100,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic                        CLK_BASE,
  input  logic                        sdif_core_reset_n_0,
  coreresetp_pcie_hotreset_mc_if.slave apb,
  output logic [NUM_SDIF-1:0]         sdif_core_reset_n,
  output logic [NUM_SDIF-1:0]         hot_reset_active,
  output logic [CNT_W*NUM_SDIF-1:0]   hot_reset_count,
  output logic [NUM_SDIF-1:0]         timeout_p
);

  for (genvar gi = 0; gi < NUM_SDIF; gi++) begin : g_chan
    coreresetp_hotreset_chan #(
      .LTSSM_LSB      (LTSSM_LSB),
      .HOLD_CYCLES    (HOLD_CYCLES),
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_chan (
      .CLK_BASE            (CLK_BASE),
      .sdif_core_reset_n_0 (sdif_core_reset_n_0),
      .psel                (apb.psel[gi]),
      .pwrite              (apb.pwrite[gi]),
      .prdata              (apb.prdata[32*gi +: 32]),
      .sdif_core_reset_n   (sdif_core_reset_n[gi]),
      .hot_reset_active    (hot_reset_active[gi]),
      .hot_reset_count     (hot_reset_count[CNT_W*gi +: CNT_W]),
      .timeout_p           (timeout_p[gi])
    );
  end

endmodule

// File: tb/tb_coreresetp_pcie_hotreset_mc.sv
// Self-checking bench: directed and randomized LTSSM sequences against a transaction-level model.
module tb_coreresetp_pcie_hotreset_mc;

  localparam int NCH  = 2;
  localparam int LSB  = 26;
  localparam int HOLD = 10;
  localparam int TMO  = 16;

  localparam logic [4:0] C_HR  = 5'b10100;
  localparam logic [4:0] C_DIS = 5'b10000;
  localparam logic [4:0] C_DQ  = 5'b00000;
  localparam logic [4:0] C_L0  = 5'b10001;

  logic CLK_BASE = 1'b0;
  logic rst_n    = 1'b0;
  always #5 CLK_BASE = ~CLK_BASE;

  coreresetp_pcie_hotreset_mc_if #(.NUM_SDIF(NCH)) apb ();

  logic [NCH-1:0]   srn;
  logic [NCH-1:0]   act;
  logic [NCH-1:0]   tmo;
  logic [8*NCH-1:0] cnt;

  coreresetp_pcie_hotreset_mc #(
    .NUM_SDIF       (NCH),
    .LTSSM_LSB      (LSB),
    .HOLD_CYCLES    (HOLD),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .CLK_BASE            (CLK_BASE),
    .sdif_core_reset_n_0 (rst_n),
    .apb                 (apb),
    .sdif_core_reset_n   (srn),
    .hot_reset_active    (act),
    .hot_reset_count     (cnt),
    .timeout_p           (tmo)
  );

  int compared   = 0;
  int mismatched = 0;
  int exp_cnt [NCH];
  int txn_no     = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge CLK_BASE);
    #1;
  endtask

  task automatic put(input int ch, input logic [4:0] code, input logic ps, input logic pw);
    logic [31:0] w;
    w = $urandom;
    w[LSB +: 5] = code;
    apb.prdata[32*ch +: 32] = w;
    apb.psel[ch]   = ps;
    apb.pwrite[ch] = pw;
  endtask

  // Detect.Quiet has just been placed on prdata; watch the whole reset window.
  task automatic measure(input int ch, input bit exp_rst, input string tag);
    int first_low, low_n, act_n, tmo_n, oth;
    bit other_ok;
    first_low = -1; low_n = 0; act_n = 0; tmo_n = 0; other_ok = 1'b1;
    oth = 1 - ch;
    for (int e = 0; e < HOLD + 16; e++) begin
      cyc();
      if (!srn[ch]) begin
        if (first_low < 0) first_low = e;
        low_n++;
      end
      if (act[ch]) act_n++;
      if (!srn[oth] || act[oth]) other_ok = 1'b0;
      if (tmo != '0) tmo_n++;
    end
    if (exp_rst) exp_cnt[ch] = (exp_cnt[ch] < 255) ? exp_cnt[ch] + 1 : 255;
    check({tag, "_latency"}, first_low, exp_rst ? 4 : -1);
    check({tag, "_low_clks"}, low_n, exp_rst ? HOLD + 3 : 0);
    check({tag, "_active_clks"}, act_n, exp_rst ? HOLD + 1 : 0);
    check({tag, "_other_quiet"}, other_ok, 1);
    check({tag, "_no_timeout"}, tmo_n, 0);
    check({tag, "_count"}, cnt[8*ch +: 8], exp_cnt[ch]);
    check({tag, "_other_count"}, cnt[8*oth +: 8], exp_cnt[oth]);
    txn_no++;
    $display("txn %0d %s ch=%0d reset=%0d low=%0d cnt=%0d", txn_no, tag, ch, exp_rst, low_n,
             cnt[8*ch +: 8]);
  endtask

  // mode 0: idle bus, 1: APB write, 2: APB read throughout, 3: read ends while code present
  task automatic txn(input int ch, input int mode, input logic [4:0] trig);
    logic ps, pw;
    ps = (mode != 0);
    pw = (mode == 1);
    put(ch, trig, ps, pw);
    repeat ($urandom_range(1, 6)) cyc();
    if (mode == 3) begin
      ps = 1'b0;
      pw = 1'b0;
      put(ch, trig, ps, pw);
      repeat ($urandom_range(1, 3)) cyc();
    end
    put(ch, C_DQ, ps, pw);
    measure(ch, mode != 2, $sformatf("m%0d", mode));
    put(ch, C_L0, 1'b0, 1'b0);
    repeat (6) cyc();
  endtask

  initial begin
    int first, n;
    for (int i = 0; i < NCH; i++) exp_cnt[i] = 0;
    apb.psel = '0;
    apb.pwrite = '0;
    apb.prdata = '0;
    put(0, C_L0, 1'b0, 1'b0);
    put(1, C_L0, 1'b0, 1'b0);

    repeat (3) cyc();
    check("rst_srn", srn, 2'b00);
    check("rst_active", act, 2'b00);
    check("rst_count", cnt, 16'h0000);
    check("rst_timeout", tmo, 2'b00);
    rst_n = 1'b1;
    cyc();
    check("release_1clk", srn, 2'b00);
    cyc();
    check("release_2clk", srn, 2'b11);

    txn(0, 0, C_HR);
    txn(0, 2, C_HR);
    txn(1, 0, C_DIS);
    txn(0, 3, C_HR);
    txn(1, 1, C_DIS);

    // HotReset with no Detect.Quiet for a long time
    put(0, C_HR, 1'b0, 1'b0);
    first = -1; n = 0;
    for (int e = 0; e < 40; e++) begin
      cyc();
      if (tmo[0]) begin
        if (first < 0) first = e;
        n++;
      end
    end
    put(0, C_DQ, 1'b0, 1'b0);
`ifdef CORERESETP_HOTRESET_TIMEOUT_EN
    check("tmo_edge", first, TMO + 4);
    check("tmo_pulses", n, 1);
    measure(0, 1'b0, "after_timeout");
`else
    check("tmo_pulses", n, 0);
    measure(0, 1'b1, "legacy_wait");
`endif
    put(0, C_L0, 1'b0, 1'b0);
    repeat (6) cyc();

    for (int i = 0; i < 24; i++) begin
      txn($urandom_range(0, 1), $urandom_range(0, 3), ($urandom_range(0, 1) != 0) ? C_HR : C_DIS);
    end

    // Upstream reset in the middle of the hold
    put(0, C_HR, 1'b0, 1'b0);
    repeat (3) cyc();
    put(0, C_DQ, 1'b0, 1'b0);
    repeat (9) cyc();
    check("midhold_active_before", act[0], 1'b1);
    rst_n = 1'b0;
    #1;
    for (int i = 0; i < NCH; i++) exp_cnt[i] = 0;
    check("midhold_srn", srn, 2'b00);
    check("midhold_active", act, 2'b00);
    check("midhold_count", cnt, 16'h0000);
    repeat (2) cyc();
    rst_n = 1'b1;
    repeat (2) cyc();
    check("midhold_release_srn", srn, 2'b11);
    check("midhold_release_active", act, 2'b00);
    check("midhold_release_count", cnt, 16'h0000);
    put(0, C_L0, 1'b0, 1'b0);
    repeat (6) cyc();

    for (int i = 0; i < 258; i++) txn(1, 0, C_HR);
    check("saturated_count", cnt[15:8], 8'd255);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/coreresetp_pcie_hotreset_mc.md
# coreresetp_pcie_hotreset_mc

Multi-channel, parametrised PCIe HotReset workaround for CoreResetP. It serves up to four PCIe-configured SDIF blocks. For each one it snoops LTSSM state on PRDATA while no APB read is in flight, detects HotReset/Disabled followed by Detect.Quiet, and asserts that SDIF's CORE reset for a programmable hold time. Unlike the single-channel block, it adds a Detect.Quiet wait timeout, per-channel status and event counters, and runs on one clock.

## Interface
- NUM_SDIF, 1: number of SDIF channels (1-4).
- LTSSM_LSB, 26: LSB of the 5-bit LTSSM field within each 32-bit PRDATA word.
- HOLD_CYCLES, 100: RESET_ASSERT dwell in clocks (2-1023).
- TIMEOUT_CYCLES, 4096: max HOTRESET_DETECT dwell (only with timeout macro, 16-65535).
- CLK_BASE  in  1  sole clock, rising edge.
- sdif_core_reset_n_0  in  1  reset: asynchronous, active-low; also the upstream CORE reset request for all channels.
- psel  in  NUM_SDIF  per-channel APB select.
- pwrite  in  NUM_SDIF  per-channel APB write.
- prdata  in  32*NUM_SDIF  per-channel PRDATA, channel i at [32i+31:32i].
- sdif_core_reset_n  out  NUM_SDIF  per-channel CORE reset to SDIF, active-low.
- hot_reset_active  out  NUM_SDIF  high while channel is in DETECT_QUIET or RESET_ASSERT.
- hot_reset_count  out  8*NUM_SDIF  per-channel saturating count of completed hot resets.
- timeout_p  out  NUM_SDIF  one-cycle pulse on HOTRESET_DETECT timeout (tied 0 without macro).

## Operation
- Per channel, pipeline: ltssm_q1/q2 take prdata[LTSSM_LSB+4:LTSSM_LSB]; psel_q1/q2 and pwrite_q1/q2 are registered alongside.
- no_apb_read = !psel_q2 | pwrite_q2. While it is low, all three level flags are forced 0.
- Level flags: HotReset (5'b10100), Disabled (5'b10000), DetectQuiet (5'b00000). Each is delayed once; entry pulse = level & !level_q.
- FSM states:
  - IDLE: go to HOTRESET_DETECT on HotReset or Disabled entry.
  - HOTRESET_DETECT: on DetectQuiet entry, go to DETECT_QUIET and drive hot_reset_n low. Timeout (macro) goes to IDLE.
  - DETECT_QUIET: clear hold_cnt, go to RESET_ASSERT.
  - RESET_ASSERT: hold_cnt increments. At hold_cnt == HOLD_CYCLES-1, go to IDLE, set hot_reset_n high, increment hot_reset_count (saturates at 255).
  - Illegal encodings: go to IDLE with hot_reset_n high.
- Widths: hold_cnt is $clog2(HOLD_CYCLES) bits; tmo_cnt is 16 bits.
- Entry pulses in DETECT_QUIET or RESET_ASSERT are ignored. A new HotReset is only tracked after returning to IDLE.
- Output reset: core_areset_n[i] = hot_reset_n[i] & sdif_core_reset_n_0. It asynchronously clears a 2-flop chain; sdif_core_reset_n[i] is the chain output, synchronous deassertion.
- Channels are fully independent; no shared state apart from reset.

## Timing
- Reset values: every flop 0 except hot_reset_n = 1, and state = IDLE.
- Outputs during and after reset: sdif_core_reset_n = 0, hot_reset_active = 0, hot_reset_count = 0, timeout_p = 0.
- sdif_core_reset_n rises 2 clocks after sdif_core_reset_n_0 deasserts.
- LTSSM code stable on prdata before edge k gives its entry pulse high after edge k+3, so the FSM acts at edge k+4.
- Assertion: sdif_core_reset_n[i] falls combinationally-asynchronously in the cycle hot_reset_n falls.
- hot_reset_n is low for exactly HOLD_CYCLES+1 clocks.
- sdif_core_reset_n[i] rises 2 clocks after hot_reset_n rises.
- hot_reset_active equals (state == DETECT_QUIET or RESET_ASSERT), registered with state.
- Mid-hold assertion of sdif_core_reset_n_0 resets the FSM, counter and status immediately; no partial count increment.
- An APB read (psel=1, pwrite=0) drops the level flags. When the read ends, a still-present code produces a fresh entry pulse.

## Configuration
- CORERESETP_HOTRESET_TIMEOUT_EN defined:
  - tmo_cnt clears on entry to HOTRESET_DETECT and increments each cycle there.
  - At tmo_cnt == TIMEOUT_CYCLES-1 with no DetectQuiet entry, go to IDLE and pulse timeout_p for 1 clock.
  - A DetectQuiet entry in the same cycle as the timeout wins.
- Undefined: no tmo_cnt, timeout_p tied 0, HOTRESET_DETECT waits indefinitely (legacy behaviour).

## Structure
- Package coreresetp_hotreset_pkg:
  - State localparams IDLE = 2'b00, HOTRESET_DETECT = 2'b01, DETECT_QUIET = 2'b10, RESET_ASSERT = 2'b11.
  - LTSSM code constants.
- Sub-module coreresetp_hotreset_chan: one channel's pipeline, FSM, counters and output synchroniser. The top generates NUM_SDIF instances and slices the buses.

## Test plan
- Reset release, NUM_SDIF=2: sdif_core_reset_n = 2'b00 during reset, 2'b11 two clocks after release, counts 0.
- Ch0 LTSSM 5'b10100 then 5'b00000, psel=0: hot_reset_n low 101 clocks (default HOLD_CYCLES), hot_reset_count[7:0] = 1, ch1 untouched.
- Same sequence with psel=1, pwrite=0 held throughout: no reset, state stays IDLE.
- Disabled (5'b10000) then Detect.Quiet with HOLD_CYCLES=10: 11-clock low pulse.
- Macro on, TIMEOUT_CYCLES=16, HotReset with no Detect.Quiet: timeout_p pulses at HOTRESET_DETECT cycle 16, state returns to IDLE, no reset.
- sdif_core_reset_n_0 asserted mid-RESET_ASSERT: outputs 0 immediately. After release, state is IDLE and hot_reset_count = 0. 256 hot resets leave the count saturated at 255.
